store_split_ctrl: RTL and testbench
===================================

Name: store_split_ctrl

Overview:
- Sequences CPU store requests onto the 32-bit data-memory write port.
- Per request: computes byte-lane placement and write strobes from the store op (SB/SH/SW) and the address.
- Splits any store that crosses a word boundary into two aligned bus beats; otherwise issues one beat.
- Sits between the multicycle core's store path and the memory/bus arbiter; reports misaligned, illegal-op and bus-timeout faults.

Parameters:
- SPLIT_EN, 1: 1 = split word-crossing stores into two beats; 0 = report them as misaligned faults.
- TIMEOUT, 255: max wait cycles per beat for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  store request valid
- req_ready  out  1  controller can accept a request
- req_addr  in  32  byte address
- req_op  in  STORE_OP_WIDTH  STORE_OP_SB/SH/SW
- req_data  in  32  store data, right-justified
- mem_valid  out  1  bus write request
- mem_ready  in  1  bus accepts the beat
- mem_addr  out  32  word-aligned address (bits [1:0] = 0)
- mem_wdata  out  32  lane-placed write data
- mem_wstrb  out  4  byte write strobes
- busy  out  1  store in progress
- done  out  1  one-cycle pulse: store completed
- fault  out  1  one-cycle pulse: store aborted
- fault_code  out  2  01 misaligned, 10 illegal op, 11 timeout; held until the next fault

Behaviour:
- Reset values: req_ready=0 while rst is high, then 1 in IDLE; all other outputs 0. State=IDLE. Reset takes effect asynchronously, including mid-beat; mem_valid drops immediately.
- States: IDLE, BEAT0, BEAT1, DONE, FAULT.
- IDLE:
  - req_ready=1.
  - On req_valid, latch: aligned address A = {req_addr[31:2],2'b00}; sh = req_addr[1:0].
  - base mask: SB 0001, SH 0011, SW 1111.
  - strb8 = base << sh (8 bits); data64 = {32'b0, req_data} << (8*sh).
- Routing from IDLE:
  - Illegal op -> FAULT, code 10.
  - strb8[7:4] != 0 and SPLIT_EN=0 -> FAULT, code 01.
  - Otherwise -> BEAT0.
  - No bus activity on any fault path.
- BEAT0:
  - mem_valid=1, mem_addr=A, mem_wstrb=strb8[3:0], mem_wdata=data64[31:0].
  - On mem_ready: if strb8[7:4]==0, go to DONE; else go to BEAT1.
- BEAT1:
  - mem_valid=1, mem_addr=A+4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000), mem_wstrb=strb8[7:4], mem_wdata=data64[63:32].
  - On mem_ready -> DONE.
- Bus signal stability: mem_addr/wdata/wstrb stay stable while mem_valid=1 and mem_ready=0. A handshake completes on the same clock edge where mem_valid&&mem_ready.
- Disabled lanes: always driven 0 (never X), so the wdata bytes outside mem_wstrb are 0.
- Timeout:
  - Counter clears on entry to each beat and increments while mem_valid&&!mem_ready.
  - With TIMEOUT>0, on reaching TIMEOUT: drop mem_valid, go to FAULT with code 11.
  - If BEAT0 already completed, its write is NOT rolled back.
- DONE: done=1 for one cycle -> IDLE. FAULT: fault=1 for one cycle -> IDLE. busy=1 in every state except IDLE.
- Latency: request accepted at edge N; mem_valid high from cycle N+1. Zero-wait bus: single beat gives done at N+2; split store gives done at N+3.
- Back-to-back: a new request is accepted only in IDLE, one cycle after done/fault.
- Simultaneous mem_ready and a timeout hit in the same cycle: mem_ready wins and the beat completes.

Decomposition:
- Shared package/defines (riscv_defines): STORE_OP_* encodings, STORE_OP_WIDTH, FAULT_* codes, and state encodings.
- One natural sub-module, store_lane_shift: combinational; maps (op, sh, data) to (strb8, data64, illegal). Everything else is the FSM plus the timeout counter.

Test Plan:
- SB, addr 0x00001003, data 0x000000AB -> one beat: addr 0x1000, wstrb 1000, wdata 0xAB000000; done at N+2.
- SW, addr 0x00001002, data 0x11223344, SPLIT_EN=1 -> beat0: 0x1000 / 1100 / 0x33440000; beat1: 0x1004 / 0011 / 0x00001122; then done.
- SH, addr 0x00001003, SPLIT_EN=0 -> fault pulse, fault_code=01, mem_valid never asserted. Illegal op -> fault_code=10.
- SH at 0x2002 with mem_ready held low 5 cycles -> mem_addr 0x2000, wstrb 1100 and wdata stable for all 5 cycles; done one cycle after the handshake.
- TIMEOUT=8, mem_ready never asserted -> mem_valid falls after 8 wait cycles, fault_code=11. Also: rst pulsed mid-BEAT1 -> all outputs 0 asynchronously, state IDLE.
- SW at 0xFFFFFFFE, data 0xCAFEBABE -> beat0: 0xFFFFFFFC / 1100 / 0xBABE0000; beat1: 0x00000000 / 0011 / 0x0000CAFE.

Source files
------------

// File: rtl/store_split_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// store_split_ctrl_pkg
// Shared definitions for the store sequencer: store-op encodings, fault codes,
// controller state encoding and the per-op base byte mask.
// No ports; imported by store_lane_shift and store_split_ctrl.
// ---------------------------------------------------------------------------
package store_split_ctrl_pkg;

    localparam int STORE_OP_WIDTH = 2;

    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 2'b00;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 2'b01;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 2'b10;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
        ST_BEAT1 = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // Lanes touched by an op when the address is word aligned; zero for
    // encodings that are not a legal store.
    function automatic logic [3:0] baseMask(input logic [STORE_OP_WIDTH-1:0] op);
        logic [3:0] mask;
        mask = 4'b0000;
        case (op)
            STORE_OP_SB: mask = 4'b0001;
            STORE_OP_SH: mask = 4'b0011;
            STORE_OP_SW: mask = 4'b1111;
            default:     mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_lane_shift.sv
// ---------------------------------------------------------------------------
// store_lane_shift
// Purely combinational byte-lane placement for one store request.
//   op_i      : store op (SB/SH/SW)
//   sh_i      : byte offset inside the word (address bits [1:0])
//   data_i    : right-justified store data
//   strb8_o   : strobes across two consecutive words ([3:0] first word)
//   data64_o  : lane-placed data across two words, unused bytes forced to 0
//   illegal_o : op encoding is not a legal store
// ---------------------------------------------------------------------------
module store_lane_shift
    import store_split_ctrl_pkg::*;
(
    input  logic [STORE_OP_WIDTH-1:0] op_i,
    input  logic [1:0]                sh_i,
    input  logic [31:0]               data_i,
    output logic [7:0]                strb8_o,
    output logic [63:0]               data64_o,
    output logic                      illegal_o
);

    logic [3:0]  base;
    logic [31:0] keep;

    // Bytes above the op size are masked before shifting so that any lane
    // without a strobe carries 0 rather than stale upper data bits.
    always_comb begin
        base      = baseMask(op_i);
        keep      = 32'h0000_0000;
        illegal_o = 1'b0;
        case (op_i)
            STORE_OP_SB: keep = 32'h0000_00FF;
            STORE_OP_SH: keep = 32'h0000_FFFF;
            STORE_OP_SW: keep = 32'hFFFF_FFFF;
            default:     illegal_o = 1'b1;
        endcase
        strb8_o  = {4'b0000, base} << sh_i;
        data64_o = {32'h0000_0000, data_i & keep} << {sh_i, 3'b000};
    end

endmodule

// File: rtl/store_split_ctrl.sv
// ---------------------------------------------------------------------------
// store_split_ctrl
// Sequences CPU stores onto a 32-bit memory write port, splitting stores that
// cross a word boundary into two aligned beats.
//   clk, rst                       : clock, async active-high reset
//   req_valid/req_ready            : request handshake from the core
//   req_addr/req_op/req_data       : byte address, store op, right-justified data
//   mem_valid/mem_ready            : bus write handshake
//   mem_addr/mem_wdata/mem_wstrb   : word-aligned beat address, data, strobes
//   busy                           : store in progress (any state but IDLE)
//   done/fault                     : one-cycle completion / abort pulses
//   fault_code                     : last fault cause, held until the next one
// Parameters: SPLIT_EN (1 = split word-crossing stores, 0 = misaligned fault),
//             TIMEOUT (wait cycles allowed per beat, 0 = never time out).
// ---------------------------------------------------------------------------
module store_split_ctrl
    import store_split_ctrl_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1,
    parameter int TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic [STORE_OP_WIDTH-1:0] req_op,
    input  logic [31:0]               req_data,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_wstrb,
    output logic                      busy,
    output logic                      done,
    output logic                      fault,
    output logic [1:0]                fault_code
);

    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LIM);

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [7:0]        strb_q, strb_d;
    logic [63:0]       data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        code_q, code_d;

    logic [7:0]        reqStrb8;
    logic [63:0]       reqData64;
    logic              reqIllegal;

    store_lane_shift u_lane_shift (
        .op_i      (req_op),
        .sh_i      (req_addr[1:0]),
        .data_i    (req_data),
        .strb8_o   (reqStrb8),
        .data64_o  (reqData64),
        .illegal_o (reqIllegal)
    );

    // State register plus the latched request and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0000_0000;
            strb_q  <= 8'h00;
            data_q  <= 64'h0;
            cnt_q   <= '0;
            code_q  <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Next-state logic. The timeout is only evaluated in cycles where
    // mem_ready is low, so a ready arriving on the last allowed cycle always
    // completes the beat. The counter returns to zero on every handshake so
    // the second beat gets its own full wait budget.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    addr_d = {req_addr[31:2], 2'b00};
                    strb_d = reqStrb8;
                    data_d = reqData64;
                    if (reqIllegal) begin
                        state_d = ST_FAULT;
                        code_d  = FAULT_ILLEGAL;
                    end else if ((reqStrb8[7:4] != 4'b0000) && !SPLIT_EN) begin
                        state_d = ST_FAULT;
                        code_d  = FAULT_MISALIGN;
                    end else begin
                        state_d = ST_BEAT0;
                    end
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                if (mem_ready) begin
                    cnt_d = '0;
                    if ((state_q == ST_BEAT0) && (strb_q[7:4] != 4'b0000)) begin
                        state_d = ST_BEAT1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_FAULT;
                    code_d  = FAULT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from the state so an async reset clears the
    // bus request immediately. Bus fields are 0 whenever mem_valid is low.
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !rst;
        busy      = (state_q != ST_IDLE);
        mem_valid = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        mem_wstrb = 4'b0000;
        done      = 1'b0;
        fault     = 1'b0;
        case (state_q)
            ST_BEAT0: begin
                mem_valid = 1'b1;
                mem_addr  = addr_q;
                mem_wstrb = strb_q[3:0];
                mem_wdata = data_q[31:0];
            end
            ST_BEAT1: begin
                mem_valid = 1'b1;
                mem_addr  = addr_q + 32'd4;
                mem_wstrb = strb_q[7:4];
                mem_wdata = data_q[63:32];
            end
            ST_DONE:  done  = 1'b1;
            ST_FAULT: fault = 1'b1;
            default: begin
            end
        endcase
    end

    assign fault_code = code_q;

endmodule

// File: tb/tb_store_split_ctrl.sv
// ---------------------------------------------------------------------------
// tb_store_split_ctrl
// Self-checking bench for store_split_ctrl: reset behaviour, a table of
// directed stores, randomized stores against a byte-address reference model,
// an async reset in the middle of a split store, and a SPLIT_EN=0 instance.
// ---------------------------------------------------------------------------
module tb_store_split_ctrl;

    localparam int TOUT = 8;

    typedef struct packed {
        logic [1:0]  nb;
        logic [1:0]  code;
        logic [31:0] a0;
        logic [3:0]  s0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  s1;
        logic [31:0] d1;
    } beatsT;

    typedef struct packed {
        logic        rdy;
        logic        reqReady;
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        busy;
        logic        done;
        logic        fault;
        logic [1:0]  code;
    } cycT;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  op;
        logic [31:0] data;
        logic [3:0]  w0;
        logic [3:0]  w1;
        beatsT       exp;
    } vecT;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [1:0]  reqOp;
    logic [31:0] reqData;
    logic        memValid;
    logic        memReady;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memWstrb;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  faultCode;

    logic        nReqValid;
    logic        nReqReady;
    logic [31:0] nReqAddr;
    logic [1:0]  nReqOp;
    logic [31:0] nReqData;
    logic        nMemValid;
    logic        nMemReady;
    logic [31:0] nMemAddr;
    logic [31:0] nMemWdata;
    logic [3:0]  nMemWstrb;
    logic        nBusy;
    logic        nDone;
    logic        nFault;
    logic [1:0]  nFaultCode;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [1:0]  curCode;
    cycT         expQ[$];
    vecT         vecs[8];

    always #5 clk = ~clk;

    store_split_ctrl #(.SPLIT_EN(1'b1), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_ready(reqReady), .req_addr(reqAddr),
        .req_op(reqOp), .req_data(reqData),
        .mem_valid(memValid), .mem_ready(memReady), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_wstrb(memWstrb),
        .busy(busy), .done(done), .fault(fault), .fault_code(faultCode)
    );

    store_split_ctrl #(.SPLIT_EN(1'b0), .TIMEOUT(TOUT)) dutNoSplit (
        .clk(clk), .rst(rst),
        .req_valid(nReqValid), .req_ready(nReqReady), .req_addr(nReqAddr),
        .req_op(nReqOp), .req_data(nReqData),
        .mem_valid(nMemValid), .mem_ready(nMemReady), .mem_addr(nMemAddr),
        .mem_wdata(nMemWdata), .mem_wstrb(nMemWstrb),
        .busy(nBusy), .done(nDone), .fault(nFault), .fault_code(nFaultCode)
    );

    // Reference model: place each store byte at its own byte address and
    // group the results by the word they land in.
    function automatic beatsT modelStore(input logic [31:0] addr, input logic [1:0] op,
                                         input logic [31:0] data, input bit splitEn);
        beatsT       r;
        int          size;
        int          l;
        logic [31:0] base;
        logic [31:0] b;
        r    = '0;
        base = addr & 32'hFFFF_FFFC;
        r.a0 = base;
        r.a1 = base + 32'd4;
        case (op)
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        if (size == 0) begin
            r.code = 2'b10;
            return r;
        end
        for (int i = 0; i < size; i++) begin
            b = addr + 32'(i);
            l = int'(b[1:0]);
            if ((b - base) < 32'd4) begin
                r.s0[l]        = 1'b1;
                r.d0[8*l +: 8] = data[8*i +: 8];
            end else begin
                r.s1[l]        = 1'b1;
                r.d1[8*l +: 8] = data[8*i +: 8];
            end
        end
        r.nb = (r.s1 != 4'b0000) ? 2'd2 : 2'd1;
        if ((r.nb == 2'd2) && !splitEn) begin
            r.code = 2'b01;
            r.nb   = 2'd0;
        end
        return r;
    endfunction

    function automatic cycT mkRec(input logic rdy, input logic valid, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] strb,
                                  input logic bsy, input logic dn, input logic flt,
                                  input logic rr);
        cycT c;
        c.rdy = rdy; c.reqReady = rr; c.valid = valid; c.addr = addr; c.wdata = wdata;
        c.strb = strb; c.busy = bsy; c.done = dn; c.fault = flt; c.code = curCode;
        return c;
    endfunction

    // Expected per-cycle outputs for one store; a beat with w wait cycles
    // times out once TOUT consecutive waits have been seen.
    function automatic void buildSchedule(input beatsT b, input int w0, input int w1);
        bit to;
        int w;
        to = 1'b0;
        expQ.delete();
        if (b.code != 2'b00) begin
            curCode = b.code;
            expQ.push_back(mkRec(1'($urandom), 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0));
        end else begin
            for (int beat = 0; beat < int'(b.nb); beat++) begin
                w = (beat == 0) ? w0 : w1;
                for (int k = 0; k <= w; k++) begin
                    if (k == w) begin
                        expQ.push_back(mkRec(1'b1, 1'b1, beat ? b.a1 : b.a0, beat ? b.d1 : b.d0,
                                             beat ? b.s1 : b.s0, 1'b1, 1'b0, 1'b0, 1'b0));
                    end else begin
                        expQ.push_back(mkRec(1'b0, 1'b1, beat ? b.a1 : b.a0, beat ? b.d1 : b.d0,
                                             beat ? b.s1 : b.s0, 1'b1, 1'b0, 1'b0, 1'b0));
                        if (k == TOUT - 1) begin
                            to = 1'b1;
                            break;
                        end
                    end
                end
                if (to) break;
            end
            if (to) begin
                curCode = 2'b11;
                expQ.push_back(mkRec(1'($urandom), 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0));
            end else begin
                expQ.push_back(mkRec(1'($urandom), 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0));
            end
        end
        expQ.push_back(mkRec(1'($urandom), 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1));
    endfunction

    task automatic checkOutput(input string name, input cycT e);
        logic [74:0] act;
        logic [74:0] exp;
        act = {reqReady, memValid, memAddr, memWdata, memWstrb, busy, done, fault, faultCode};
        exp = {e.reqReady, e.valid, e.addr, e.wdata, e.strb, e.busy, e.done, e.fault, e.code};
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h expected %h (rr,valid,addr,wdata,strb,busy,done,fault,code)",
                     name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Present one request for a single cycle, then walk the expected schedule
    // one clock at a time, driving mem_ready from it.
    task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [1:0] op,
                                 input logic [31:0] data, input int w0, input int w1,
                                 input beatsT b);
        buildSchedule(b, w0, w1);
        @(posedge clk); #1;
        reqValid = 1'b1; reqAddr = addr; reqOp = op; reqData = data;
        memReady = 1'($urandom);
        @(negedge clk);
        checkBit({name, "_req_ready"}, reqReady, 1'b1);
        @(posedge clk); #1;
        reqValid = 1'b0; reqAddr = $urandom; reqOp = 2'($urandom); reqData = $urandom;
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            memReady = expQ[i].rdy;
            @(negedge clk);
            checkOutput($sformatf("%s_c%0d", name, i), expQ[i]);
        end
    endtask

    initial begin
        beatsT       rb;
        logic [31:0] ra;
        logic [1:0]  ro;
        logic [31:0] rd;
        int          rw0;
        int          rw1;

        vecs[0] = '{32'h0000_1003, 2'd0, 32'h0000_00AB, 4'd0, 4'd0,
                    '{2'd1, 2'b00, 32'h1000, 4'b1000, 32'hAB00_0000, 32'h1004, 4'b0000, 32'h0}};
        vecs[1] = '{32'h0000_1002, 2'd2, 32'h1122_3344, 4'd0, 4'd0,
                    '{2'd2, 2'b00, 32'h1000, 4'b1100, 32'h3344_0000, 32'h1004, 4'b0011, 32'h0000_1122}};
        vecs[2] = '{32'h0000_1000, 2'd3, 32'h1234_5678, 4'd0, 4'd0,
                    '{2'd0, 2'b10, 32'h1000, 4'b0000, 32'h0, 32'h1004, 4'b0000, 32'h0}};
        vecs[3] = '{32'h0000_2002, 2'd1, 32'h5555_BEEF, 4'd5, 4'd0,
                    '{2'd1, 2'b00, 32'h2000, 4'b1100, 32'hBEEF_0000, 32'h2004, 4'b0000, 32'h0}};
        vecs[4] = '{32'hFFFF_FFFE, 2'd2, 32'hCAFE_BABE, 4'd1, 4'd2,
                    '{2'd2, 2'b00, 32'hFFFF_FFFC, 4'b1100, 32'hBABE_0000, 32'h0000_0000, 4'b0011, 32'h0000_CAFE}};
        vecs[5] = '{32'h0000_3000, 2'd2, 32'hDEAD_BEEF, 4'd9, 4'd0,
                    '{2'd1, 2'b00, 32'h3000, 4'b1111, 32'hDEAD_BEEF, 32'h3004, 4'b0000, 32'h0}};
        vecs[6] = '{32'h0000_1002, 2'd2, 32'hA1B2_C3D4, 4'd0, 4'd8,
                    '{2'd2, 2'b00, 32'h1000, 4'b1100, 32'hC3D4_0000, 32'h1004, 4'b0011, 32'h0000_A1B2}};
        vecs[7] = '{32'h0000_1001, 2'd1, 32'h1234_5678, 4'd7, 4'd0,
                    '{2'd1, 2'b00, 32'h1000, 4'b0110, 32'h0056_7800, 32'h1004, 4'b0000, 32'h0}};

        rst = 1'b1;
        reqValid = 1'b0; reqAddr = '0; reqOp = '0; reqData = '0; memReady = 1'b0;
        nReqValid = 1'b0; nReqAddr = '0; nReqOp = '0; nReqData = '0; nMemReady = 1'b1;
        curCode = 2'b00;

        #3;
        checkOutput("reset_hold", mkRec(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_idle", mkRec(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1));

        // SPLIT_EN=0 instance: crossing SH faults without touching the bus,
        // a non-crossing SB still issues its single beat.
        @(posedge clk); #1;
        nReqValid = 1'b1; nReqAddr = 32'h0000_1003; nReqOp = 2'd1; nReqData = 32'h0000_BEEF;
        @(posedge clk); #1;
        nReqValid = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({nMemValid, nBusy, nFault, nDone, nFaultCode} !== {1'b0, 1'b1, 1'b1, 1'b0, 2'b01}) begin
            nErrors++;
            $display("[TB] FAIL nosplit_misalign: got %b expected %b",
                     {nMemValid, nBusy, nFault, nDone, nFaultCode}, {1'b0, 1'b1, 1'b1, 1'b0, 2'b01});
        end
        @(negedge clk);
        checkBit("nosplit_idle_ready", nReqReady, 1'b1);
        checkBit("nosplit_no_bus", nMemValid, 1'b0);
        @(posedge clk); #1;
        nReqValid = 1'b1; nReqAddr = 32'h0000_1003; nReqOp = 2'd0; nReqData = 32'h0000_00AB;
        @(posedge clk); #1;
        nReqValid = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({nMemValid, nMemAddr, nMemWstrb, nMemWdata} !== {1'b1, 32'h1000, 4'b1000, 32'hAB00_0000}) begin
            nErrors++;
            $display("[TB] FAIL nosplit_sb_beat: got %h expected %h",
                     {nMemValid, nMemAddr, nMemWstrb, nMemWdata}, {1'b1, 32'h1000, 4'b1000, 32'hAB00_0000});
        end
        @(negedge clk);
        checkBit("nosplit_sb_done", nDone, 1'b1);
        checkBit("nosplit_code_held", nFaultCode == 2'b01, 1'b1);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].op, vecs[i].data,
                          int'(vecs[i].w0), int'(vecs[i].w1), vecs[i].exp);
        end

        // Randomized stores against the byte-address model.
        for (int n = 0; n < 80; n++) begin
            ra  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            ro  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rd  = $urandom;
            rw0 = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 9) : $urandom_range(0, 3);
            rw1 = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 9) : $urandom_range(0, 3);
            rb  = modelStore(ra, ro, rd, 1'b1);
            applyStimulus($sformatf("rnd%0d", n), ra, ro, rd, rw0, rw1, rb);
        end

        // Async reset while the second beat of a split store is waiting.
        @(posedge clk); #1;
        reqValid = 1'b1; reqAddr = 32'h0000_1002; reqOp = 2'd2; reqData = 32'h1122_3344; memReady = 1'b0;
        @(posedge clk); #1;
        reqValid = 1'b0; memReady = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_beat0", mkRec(1'b1, 1'b1, 32'h1000, 32'h3344_0000, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        memReady = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_beat1", mkRec(1'b0, 1'b1, 32'h1004, 32'h0000_1122, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        curCode = 2'b00;
        checkOutput("rstmid_async", mkRec(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_idle", mkRec(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
